shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Shares one instance of the team's combinational shift unit (module shift) between NREQ requesters.
- Round-robin arbitration selects one requester per cycle and registers its result.
- The result is returned on a per-requester valid/ready response channel.
- Sits between the issue stages of multiple ALU lanes and a single physical shifter to save area.

Parameters:
NREQ, 2, number of requesters (2..8)
DW, 32, operand/result width (fixed 32 to match shift unit)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-low
req_valid  input  NREQ  request valid per requester
req_ready  output  NREQ  request accepted (one-hot or zero)
req_a  input  NREQ*32  operand A, requester i at [32*i+31:32*i]
req_b  input  NREQ*32  shift amount B, same packing
req_op  input  NREQ*4  operation code, requester i at [4*i+3:4*i]
rsp_valid  output  NREQ  response valid, one-hot to owning requester or zero
rsp_ready  input  NREQ  requester accepts response
rsp_result  output  32  registered shift result
rsp_zero  output  1  registered zero flag of rsp_result
rsp_err  output  1  registered: op was not a legal shift code
busy  output  1  high while a response is held (state RESP)

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Op codes:
  - 4'b0010: logical left shift.
  - 4'b0011: logical right shift.
  - 4'b0100: arithmetic right shift code.
  - All others: illegal, result 0, rsp_err=1.
- B is passed unchanged (full 32 bits).
  - Shift amounts >=32 give result 0.
  - Operands are unsigned, so 4'b0100 zero-fills.
- Reset (async assert, sync-safe deassert):
  - state=IDLE, rr_ptr=NREQ-1, owner=0.
  - rsp_result=0, rsp_zero=0, rsp_err=0.
  - rsp_valid=0, req_ready=0, busy=0.
- Arbitration, combinational:
  - Winner = first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Winner is driven onto the shift unit's inputs.
- States:
  - IDLE:
    - If any req_valid: req_ready[winner]=1.
    - On the clock edge: capture result/zero/err, owner=winner, rr_ptr=winner, go to RESP.
    - Else: req_ready=0 and stay IDLE.
  - RESP:
    - rsp_valid[owner]=1, busy=1.
    - If rsp_ready[owner]=0: hold all response registers stable; req_ready=0; stay RESP.
    - If rsp_ready[owner]=1 and any req_valid: same-cycle grant, req_ready[winner]=1; capture the new result, update owner and rr_ptr; stay RESP.
    - If rsp_ready[owner]=1 and no req_valid: go to IDLE; rsp_valid=0 next cycle; response registers keep their values.
- Latency: request handshake at edge N gives rsp_valid at cycle N+1.
  - Sustained throughput is 1 op/cycle when responses are consumed immediately.
- rsp_ready on non-owner bits is ignored.
- req_ready is never asserted to a requester with req_valid=0.
- At most one req_ready bit high.
- A requester may hold req_valid high across cycles without being granted.
  - Its operands must stay stable until req_ready.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ-1 grants.
- Reset mid-operation: any held response is discarded, outputs return to reset values immediately, and rr_ptr returns to NREQ-1.

Test Plan:
- Reset, then req0 only: a=32'h0000_0001, b=4, op=0010 -> req_ready[0] in the same cycle; next cycle rsp_valid=2'b01, rsp_result=32'h10, rsp_zero=0, rsp_err=0.
- Both valid every cycle, both rsp_ready=1: req0 a=32'h8000_0000 b=31 op=0011, req1 a=32'hF0 b=4 op=0100 -> grants alternate 0,1,0,1 (0 first after reset); results alternate 32'h1 and 32'hF; one response per cycle.
- Backpressure: grant req1, hold rsp_ready[1]=0 for 3 cycles while req0 valid -> rsp_result stable, busy=1, req_ready=0 throughout; then rsp_ready[1]=1 -> same-cycle req_ready[0]=1, and the next cycle shows req0's result.
- Boundaries: a=32'hFFFF_FFFF, b=32 op=0010 -> result 0, rsp_zero=1. Op=4'b0111 -> result 0, rsp_zero=1, rsp_err=1.
- Wrong-owner ready: owner=0, rsp_ready=2'b10 -> response held, no state change.
- Assert rst_n=0 mid-RESP -> rsp_valid, busy and rsp_result drop to 0 asynchronously. After release, first grant goes to requester 0 when both are valid.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin arbiter that time-shares one combinational shift unit between
// NREQ requesters and returns each registered result on a valid/ready channel.

module shift (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        err_o
);

  // Operands are unsigned, so the arithmetic-right code zero-fills like the logical one.
  always_comb begin
    result_o = 32'd0;
    err_o    = 1'b0;
    case (op_i)
      4'b0010: result_o = (b_i >= 32'd32) ? 32'd0 : (a_i << b_i[4:0]);
      4'b0011,
      4'b0100: result_o = (b_i >= 32'd32) ? 32'd0 : (a_i >> b_i[4:0]);
      default: err_o = 1'b1;
    endcase
    zero_o = (result_o == 32'd0);
  end

endmodule

module shift_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ*4-1:0]  req_op,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [DW-1:0]      rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [DW-1:0]   result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic [IW-1:0]   win_s;
  logic            any_valid_s;
  logic            grant_s;
  logic [DW-1:0]   sel_a_s, sel_b_s, sel_result_s;
  logic [3:0]      sel_op_s;
  logic            sel_zero_s, sel_err_s;

  // Search runs farthest-to-nearest so the last hit is the first requester after rr_ptr.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    win_s       = '0;
    any_valid_s = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand        = (int'(rr_ptr_q) + k) % NREQ;
      cand_idx    = IW'(cand);
      any_valid_s = any_valid_s | req_valid[cand_idx];
      if (req_valid[cand_idx]) begin
        win_s = cand_idx;
      end else begin
        win_s = win_s;
      end
    end
  end

  // Route the winner's operands to the shared shift unit.
  always_comb begin
    sel_a_s  = '0;
    sel_b_s  = '0;
    sel_op_s = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_s == IW'(i)) begin
        sel_a_s  = req_a[i*DW +: DW];
        sel_b_s  = req_b[i*DW +: DW];
        sel_op_s = req_op[i*4 +: 4];
      end else begin
        sel_op_s = sel_op_s;
      end
    end
  end

  shift u_shift (
    .a_i      (sel_a_s),
    .b_i      (sel_b_s),
    .op_i     (sel_op_s),
    .result_o (sel_result_s),
    .zero_o   (sel_zero_s),
    .err_o    (sel_err_s)
  );

  // Next-state: a grant is possible when idle or when the owner drains its response this cycle.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    result_d  = result_q;
    zero_d    = zero_q;
    err_d     = err_q;
    grant_s   = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (any_valid_s) grant_s = 1'b1;
        else             state_d = IDLE;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          if (any_valid_s) grant_s = 1'b1;
          else             state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_s) begin
      req_ready[win_s] = 1'b1;
      state_d          = RESP;
      owner_d          = win_s;
      rr_ptr_d         = win_s;
      result_d         = sel_result_s;
      zero_d           = sel_zero_s;
      err_d            = sel_err_s;
    end else begin
      req_ready = '0;
    end
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= IW'(NREQ - 1);
      owner_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  // Response valid decodes the owner while a response is held.
  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
    else                 rsp_valid = '0;
  end

  assign busy       = (state_q == RESP);
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

endmodule
